// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// 8N1 UART transmitter with a byte FIFO in front of it. Bytes are written over
// a valid/ready handshake, buffered in a circular buffer, and then sent out
// LSB first as 1 start bit, 8 data bits and 1 stop bit. Each bit lasts
// CLKS_PER_BIT clocks. Frames go out back to back while the FIFO has data.
//
// Parameters
//   CLKS_PER_BIT : clocks per serial bit (>= 2)
//   FIFO_DEPTH   : number of byte entries (power of 2, >= 2)
//
// Ports
//   clock       : sole clock, rising edge
//   reset       : synchronous, active-high reset
//   in_data     : byte to transmit
//   in_valid    : in_data is valid this cycle
//   in_ready    : FIFO can accept a byte (not full)
//   tx          : registered serial output, idles high
//   busy        : frame in progress or FIFO non-empty
//   fifo_level  : number of bytes currently buffered
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [7:0]                         in_data,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic                               tx,
    output logic                               busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    // ------------------------------------------------------------------
    // FIFO storage and pointers. Pointers carry one extra MSB so that
    // full and empty can be told apart when the address bits match.
    // ------------------------------------------------------------------
    logic [7:0]    mem [0:FIFO_DEPTH-1];
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    // Ready depends on the pointers only, so a pop in the same cycle never
    // frees a slot for a push in that cycle.
    assign in_ready = !full;
    assign push     = in_valid && !full;

    assign wr_ptr_next = push ? (wr_ptr_reg + PW'(1)) : wr_ptr_reg;
    assign rd_ptr_next = pop  ? (rd_ptr_reg + PW'(1)) : rd_ptr_reg;

    assign fifo_level = LW'(wr_ptr_reg - rd_ptr_reg);

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= in_data;
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    logic [1:0]    state_reg, state_next;
    logic [BW-1:0] baud_cnt_reg, baud_cnt_next;
    logic [2:0]    bit_cnt_reg, bit_cnt_next;
    logic [7:0]    shift_reg;
    logic          shift_en;
    logic          baud_done;
    logic          tx_reg, tx_next;

    assign baud_done = (baud_cnt_reg == BAUD_LAST);

    always_comb begin
        state_next    = state_reg;
        baud_cnt_next = baud_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        pop           = 1'b0;
        shift_en      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!empty) begin
                    pop           = 1'b1;
                    baud_cnt_next = '0;
                    bit_cnt_next  = '0;
                    state_next    = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_cnt_next = '0;
                    state_next    = DATA;
                end else begin
                    baud_cnt_next = baud_cnt_reg + BW'(1);
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_cnt_next = '0;
                    shift_en      = 1'b1;
                    bit_cnt_next  = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = STOP;
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg + BW'(1);
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_cnt_next = '0;
                    // Chain straight into the next start bit when data is
                    // already waiting, so frames stay contiguous.
                    if (!empty) begin
                        pop          = 1'b1;
                        bit_cnt_next = '0;
                        state_next   = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg + BW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The line level follows the current state, so tx trails the state
    // register by one clock (e.g. START entered at edge k+1, tx low at k+2).
    always_comb begin
        case (state_reg)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_reg[0];
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= IDLE;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            tx_reg       <= 1'b1;
        end else begin
            state_reg    <= state_next;
            baud_cnt_reg <= baud_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            tx_reg       <= tx_next;
        end
    end

    // Registered read of the FIFO head straight into the shift register.
    always_ff @(posedge clock) begin
        if (pop) begin
            shift_reg <= mem[rd_ptr_reg[AW-1:0]];
        end else if (shift_en) begin
            shift_reg <= {1'b0, shift_reg[7:1]};
        end
    end

    assign tx   = tx_reg;
    assign busy = (state_reg != IDLE) || (fifo_level != '0);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Stimulus pushes accepted bytes into a scoreboard queue; a separate monitor
// decodes every frame on tx and compares it against the queue head.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_level;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [7:0] sb[$];
    int         falls[$];

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock      (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bench sits at negedges; one call crosses exactly one rising edge.
    task automatic tick();
        if (in_valid && in_ready) sb.push_back(in_data);
        @(negedge clk);
    endtask

    task automatic wait_idle(input int limit, output int n);
        n = 0;
        while (busy !== 1'b0 && n < limit) begin
            tick();
            n++;
        end
        if (busy !== 1'b0) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_idle: busy still high after %0d cycles", limit);
        end
    endtask

    // Serial monitor: samples every cycle of a frame, requires each bit to be
    // stable for CPB cycles, then compares the byte against the scoreboard.
    initial begin : monitor
        logic [9:0] bits;
        logic       glitch;
        logic       aborted;
        logic [7:0] data;
        logic [7:0] expv;
        int         start_cyc;
        forever begin
            @(negedge clk);
            if (tx === 1'b0 && reset === 1'b0) begin
                start_cyc = cyc;
                glitch    = 1'b0;
                aborted   = 1'b0;
                bits      = '0;
                for (int n = 0; n < 10 * CPB; n++) begin
                    if (n != 0) @(negedge clk);
                    if (reset === 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (n % CPB == 0) bits[n / CPB] = tx;
                    else if (tx !== bits[n / CPB]) glitch = 1'b1;
                end
                if (!aborted) begin
                    falls.push_back(start_cyc);
                    data = bits[8:1];
                    check("stop_bit", {31'd0, bits[9]}, 32'd1);
                    check("bit_timing", {31'd0, glitch}, 32'd0);
                    if (sb.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL frame_unexpected: got 0x%02h, expected no frame", data);
                    end else begin
                        expv = sb.pop_front();
                        $display("frame @%0d: got 0x%02h expected 0x%02h", start_cyc, data, expv);
                        check("frame_data", {24'd0, data}, {24'd0, expv});
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int         n;
        int         acc_cyc;
        logic [7:0] t4_bytes [6];
        int         t4_level [5];

        t4_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        t4_level = '{1, 1, 2, 3, 4};

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_level", {29'd0, fifo_level}, 32'd0);
        reset = 1'b0;
        tick();
        tick();

        // Single byte 0x55: latency and busy duration
        falls.delete();
        in_valid = 1'b1;
        in_data  = 8'h55;
        tick();
        acc_cyc  = cyc;
        in_valid = 1'b0;
        check("t1_level_k", {29'd0, fifo_level}, 32'd1);
        check("t1_busy_k", {31'd0, busy}, 32'd1);
        check("t1_tx_k", {31'd0, tx}, 32'd1);
        tick();
        check("t1_level_k1", {29'd0, fifo_level}, 32'd0);
        check("t1_tx_k1", {31'd0, tx}, 32'd1);
        tick();
        check("t1_tx_k2", {31'd0, tx}, 32'd0);
        wait_idle(100, n);
        check("t1_busy_cycles", n, 39);
        repeat (3) tick();
        check("t1_frames", falls.size(), 1);
        if (falls.size() >= 1) check("t1_fall_latency", falls[0] - acc_cyc, 2);

        // Single byte 0xA3: LSB-first decode
        in_valid = 1'b1;
        in_data  = 8'hA3;
        tick();
        in_valid = 1'b0;
        wait_idle(100, n);
        check("t2_busy_cycles", n, 41);
        repeat (3) tick();

        // Back-to-back 0x00, 0xFF, 0x3C
        falls.delete();
        in_valid = 1'b1;
        in_data  = 8'h00;
        tick();
        check("t3_level_a", {29'd0, fifo_level}, 32'd1);
        in_data = 8'hFF;
        tick();
        check("t3_level_b", {29'd0, fifo_level}, 32'd1);
        in_data = 8'h3C;
        tick();
        check("t3_level_c", {29'd0, fifo_level}, 32'd2);
        in_valid = 1'b0;
        repeat (39) tick();
        check("t3_level_frame2", {29'd0, fifo_level}, 32'd1);
        repeat (40) tick();
        check("t3_level_frame3", {29'd0, fifo_level}, 32'd0);
        wait_idle(100, n);
        repeat (3) tick();
        check("t3_frames", falls.size(), 3);
        if (falls.size() >= 3) begin
            check("t3_gap_1_2", falls[1] - falls[0], 40);
            check("t3_gap_2_3", falls[2] - falls[1], 40);
        end

        // FIFO full with held in_valid; simultaneous push/pop at full
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = t4_bytes[i];
            tick();
            check("t4_level", {29'd0, fifo_level}, t4_level[i]);
            if (i == 3) check("t4_ready_l3", {31'd0, in_ready}, 32'd1);
        end
        check("t4_ready_full", {31'd0, in_ready}, 32'd0);
        in_data = t4_bytes[5];
        repeat (36) tick();
        check("t4_level_hold", {29'd0, fifo_level}, 32'd4);
        check("t4_ready_hold", {31'd0, in_ready}, 32'd0);
        tick();
        check("t4_level_pop_at_full", {29'd0, fifo_level}, 32'd3);
        check("t4_ready_after_pop", {31'd0, in_ready}, 32'd1);
        tick();
        check("t4_level_refill", {29'd0, fifo_level}, 32'd4);
        in_valid = 1'b0;
        wait_idle(400, n);
        repeat (3) tick();
        check("t4_sb_drained", sb.size(), 0);

        // Reset during data bit 4 with two bytes queued
        in_valid = 1'b1;
        in_data  = 8'hA1;
        tick();
        in_data = 8'hB2;
        tick();
        in_data = 8'hC3;
        tick();
        in_valid = 1'b0;
        check("t5_level_queued", {29'd0, fifo_level}, 32'd2);
        repeat (20) tick();
        reset = 1'b1;
        sb.delete();
        tick();
        check("t5_rst_tx", {31'd0, tx}, 32'd1);
        check("t5_rst_level", {29'd0, fifo_level}, 32'd0);
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        check("t5_rst_ready", {31'd0, in_ready}, 32'd1);
        reset = 1'b0;
        repeat (45) tick();
        check("t5_idle_tx", {31'd0, tx}, 32'd1);
        falls.delete();
        in_valid = 1'b1;
        in_data  = 8'h5A;
        tick();
        in_valid = 1'b0;
        wait_idle(100, n);
        repeat (3) tick();
        check("t5_frames", falls.size(), 1);
        check("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
